// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache controller: FSM state encoding and
// default parameter values.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      ALLOCATE   = 2'd2
   } state_t;

   localparam int unsigned DEF_WAYS  = 4;
   localparam int unsigned DEF_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear wins over increment; increment stops at the all-ones value.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/nway_cache_control.sv
// Control FSM for an N-way set-associative, write-back, write-allocate cache.
// Sequences hit responses, dirty-victim write-back and line refill.
// Optional feature: define CACHE_PERF_CNT_EN to add hit/miss/write-back
// performance counters (hit_count, miss_count, wb_count).
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | waiting for a request; hits answered combinationally
//   WRITE_BACK | dirty victim line being written to memory
//   ALLOCATE   | missing line being read from memory into victim_way
module nway_cache_control
   import cache_pkg::*;
#(
   parameter  int unsigned WAYS  = DEF_WAYS,
   parameter  int unsigned CNT_W = DEF_CNT_W,
   localparam int unsigned WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   input  logic             hit_any,
   input  logic [WAYS-1:0]  dirty_out,
   input  logic [WAY_W-1:0] lru_out,
   output logic [WAY_W-1:0] victim_way,
   output logic             idling,
   output logic             w_back,
   output logic             alloc,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
`endif
);

   state_t state;
   state_t state_next;
   logic   request;
   logic   miss_start;
   logic   victim_dirty;

   // A simultaneous read and write is one request.
   assign request = mem_read | mem_write;

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Victim way is captured only on the cycle a miss leaves IDLE, so lru_out
   // movement during write-back/refill has no effect on the targeted way.
   always_ff @(posedge clk) begin
      if (rst)
         victim_way <= '0;
      else if (miss_start)
         victim_way <= lru_out;
   end

   // Next-state and Moore/Mealy outputs.
   always_comb begin
      state_next   = state;
      mem_resp     = 1'b0;
      idling       = 1'b0;
      w_back       = 1'b0;
      alloc        = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      miss_start   = 1'b0;
      victim_dirty = dirty_out[lru_out];
      case (state)
         IDLE: begin
            idling = 1'b1;
            if (request && hit_any) begin
               mem_resp = 1'b1;
            end else if (request) begin
               miss_start = 1'b1;
               state_next = victim_dirty ? WRITE_BACK : ALLOCATE;
            end
         end
         WRITE_BACK: begin
            w_back     = 1'b1;
            pmem_write = 1'b1;
            if (pmem_resp)
               state_next = ALLOCATE;
         end
         ALLOCATE: begin
            alloc     = 1'b1;
            pmem_read = 1'b1;
            if (pmem_resp)
               state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef CACHE_PERF_CNT_EN
   logic wb_start;

   // Entry into WRITE_BACK happens only from a dirty-victim miss.
   assign wb_start = miss_start & victim_dirty;

   sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (mem_resp),
      .count (hit_count)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_start),
      .count (miss_count)
   );

   sat_counter #(.W(CNT_W)) u_wb_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wb_start),
      .count (wb_count)
   );
`endif

endmodule

// File: tb/tb_nway_cache_control.sv
// Self-checking bench for nway_cache_control: a 4-way instance (2-bit
// counters) and an 8-way instance (8-bit counters) share the control inputs.
// A transaction-level reference model predicts every output each cycle.
module tb_nway_cache_control;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_read, mem_write, hit_any, pmem_resp;
   logic [3:0] dirty_a;
   logic [1:0] lru_a;
   logic [7:0] dirty_b;
   logic [2:0] lru_b;

   logic       resp_a, idl_a, wb_a, al_a, pr_a, pw_a;
   logic [1:0] vic_a;
   logic       resp_b, idl_b, wb_b, al_b, pr_b, pw_b;
   logic [2:0] vic_b;
`ifdef CACHE_PERF_CNT_EN
   logic [1:0] hc_a, mc_a, wc_a;
   logic [7:0] hc_b, mc_b, wc_b;
`endif

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   nway_cache_control #(.WAYS(4), .CNT_W(2)) dut_a (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(resp_a), .hit_any(hit_any), .dirty_out(dirty_a),
      .lru_out(lru_a), .victim_way(vic_a), .idling(idl_a), .w_back(wb_a),
      .alloc(al_a), .pmem_read(pr_a), .pmem_write(pw_a), .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_CNT_EN
      , .hit_count(hc_a), .miss_count(mc_a), .wb_count(wc_a)
`endif
   );

   nway_cache_control #(.WAYS(8), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(resp_b), .hit_any(hit_any), .dirty_out(dirty_b),
      .lru_out(lru_b), .victim_way(vic_b), .idling(idl_b), .w_back(wb_b),
      .alloc(al_b), .pmem_read(pr_b), .pmem_write(pw_b), .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_CNT_EN
      , .hit_count(hc_b), .miss_count(mc_b), .wb_count(wc_b)
`endif
   );

   // Reference model: per instance, which memory phase is outstanding
   // (none, write-back pending, refill pending), the chosen victim, and
   // event tallies capped at the counter maximum.
   typedef enum int {PH_NONE, PH_WB, PH_FILL} phase_t;
   phase_t m_phase [2];
   int     m_victim[2];
   int     m_hits  [2];
   int     m_miss  [2];
   int     m_wbs   [2];
   int     m_max   [2] = '{3, 255};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lru_of(input int i);
      return (i == 0) ? int'(lru_a) : int'(lru_b);
   endfunction

   function automatic bit dirty_of(input int i, input int way);
      return (i == 0) ? dirty_a[way] : dirty_b[way];
   endfunction

   task automatic model_check();
      bit req = mem_read | mem_write;
      for (int i = 0; i < 2; i++) begin
         bit e_idle = (m_phase[i] == PH_NONE);
         bit e_resp = e_idle && req && hit_any;
         bit e_wb   = (m_phase[i] == PH_WB);
         bit e_fill = (m_phase[i] == PH_FILL);
         if (i == 0) begin
            chk("a.mem_resp", 32'(resp_a), 32'(e_resp));
            chk("a.idling",   32'(idl_a),  32'(e_idle));
            chk("a.w_back",   32'(wb_a),   32'(e_wb));
            chk("a.pmem_write", 32'(pw_a), 32'(e_wb));
            chk("a.alloc",    32'(al_a),   32'(e_fill));
            chk("a.pmem_read", 32'(pr_a),  32'(e_fill));
            chk("a.victim",   32'(vic_a),  32'(m_victim[0]));
`ifdef CACHE_PERF_CNT_EN
            chk("a.hit_count",  32'(hc_a), 32'(m_hits[0]));
            chk("a.miss_count", 32'(mc_a), 32'(m_miss[0]));
            chk("a.wb_count",   32'(wc_a), 32'(m_wbs[0]));
`endif
         end else begin
            chk("b.mem_resp", 32'(resp_b), 32'(e_resp));
            chk("b.idling",   32'(idl_b),  32'(e_idle));
            chk("b.w_back",   32'(wb_b),   32'(e_wb));
            chk("b.pmem_write", 32'(pw_b), 32'(e_wb));
            chk("b.alloc",    32'(al_b),   32'(e_fill));
            chk("b.pmem_read", 32'(pr_b),  32'(e_fill));
            chk("b.victim",   32'(vic_b),  32'(m_victim[1]));
`ifdef CACHE_PERF_CNT_EN
            chk("b.hit_count",  32'(hc_b), 32'(m_hits[1]));
            chk("b.miss_count", 32'(mc_b), 32'(m_miss[1]));
            chk("b.wb_count",   32'(wc_b), 32'(m_wbs[1]));
`endif
         end
      end
   endtask

   task automatic model_update();
      bit req = mem_read | mem_write;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_phase[i] = PH_NONE; m_victim[i] = 0;
            m_hits[i] = 0; m_miss[i] = 0; m_wbs[i] = 0;
         end else begin
            case (m_phase[i])
               PH_NONE: begin
                  if (req && hit_any) begin
                     if (m_hits[i] < m_max[i]) m_hits[i]++;
                  end else if (req) begin
                     if (m_miss[i] < m_max[i]) m_miss[i]++;
                     m_victim[i] = lru_of(i);
                     if (dirty_of(i, lru_of(i))) begin
                        if (m_wbs[i] < m_max[i]) m_wbs[i]++;
                        m_phase[i] = PH_WB;
                     end else begin
                        m_phase[i] = PH_FILL;
                     end
                  end
               end
               PH_WB:   if (pmem_resp) m_phase[i] = PH_FILL;
               default: if (pmem_resp) m_phase[i] = PH_NONE;
            endcase
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input bit r, input bit rd, input bit wr, input bit h, input bit pr);
      rst = r; mem_read = rd; mem_write = wr; hit_any = h; pmem_resp = pr;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0);
      advance();
      advance();
      rst = 1'b0;
   endtask

   typedef struct {
      bit       rd, wr, hit, presp;
      bit [3:0] dirty;
      bit [1:0] lru;
      bit       e_resp, e_idle, e_wb, e_alloc;
      bit [1:0] e_vic;
   } vec_t;

   vec_t tbl[12];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //          rd wr hit presp dirty     lru   resp idle wb alloc vic
      tbl[0]  = '{1, 0, 1, 0, 4'b0000, 2'd0, 1, 1, 0, 0, 2'd0};
      tbl[1]  = '{0, 1, 1, 0, 4'b0000, 2'd0, 1, 1, 0, 0, 2'd0};
      tbl[2]  = '{1, 1, 1, 0, 4'b0000, 2'd0, 1, 1, 0, 0, 2'd0};
      tbl[3]  = '{0, 0, 0, 1, 4'b0000, 2'd0, 0, 1, 0, 0, 2'd0};
      tbl[4]  = '{1, 0, 0, 0, 4'b0000, 2'd1, 0, 1, 0, 0, 2'd0};
      tbl[5]  = '{1, 0, 0, 0, 4'b1111, 2'd3, 0, 0, 0, 1, 2'd1};
      tbl[6]  = '{1, 0, 0, 1, 4'b0000, 2'd3, 0, 0, 0, 1, 2'd1};
      tbl[7]  = '{1, 0, 1, 0, 4'b0000, 2'd3, 1, 1, 0, 0, 2'd1};
      tbl[8]  = '{0, 1, 0, 0, 4'b0100, 2'd2, 0, 1, 0, 0, 2'd1};
      tbl[9]  = '{0, 1, 0, 1, 4'b0000, 2'd0, 0, 0, 1, 0, 2'd2};
      tbl[10] = '{0, 0, 0, 1, 4'b0000, 2'd0, 0, 0, 0, 1, 2'd2};
      tbl[11] = '{0, 0, 0, 1, 4'b0000, 2'd0, 0, 1, 0, 0, 2'd2};

      dirty_a = '0; lru_a = '0; dirty_b = '0; lru_b = '0;
      m_phase = '{PH_NONE, PH_NONE};
      m_victim = '{0, 0}; m_hits = '{0, 0}; m_miss = '{0, 0}; m_wbs = '{0, 0};

      // Reset state.
      do_reset();
      settle();
      chk("rst.idling", 32'(idl_a), 32'd1);
      chk("rst.pmem_read", 32'(pr_a | pr_b), 32'd0);
      chk("rst.pmem_write", 32'(pw_a | pw_b), 32'd0);
      chk("rst.victim", 32'(vic_a) + 32'(vic_b), 32'd0);

      // Single hit: same-cycle response, then hit_count=1.
      advance();
      drive(0, 1, 0, 1, 0);
      settle();
      chk("hit.mem_resp", 32'(resp_a), 32'd1);
      advance();
      drive(0, 0, 0, 0, 0);
      settle();
      chk("hit.idling", 32'(idl_a), 32'd1);
`ifdef CACHE_PERF_CNT_EN
      chk("hit.hit_count", 32'(hc_a), 32'd1);
`endif
      advance();

      // Table-driven sequence on the 4-way instance, one row per cycle.
      for (int k = 0; k < 12; k++) begin
         drive(0, tbl[k].rd, tbl[k].wr, tbl[k].hit, tbl[k].presp);
         dirty_a = tbl[k].dirty; lru_a = tbl[k].lru;
         settle();
         chk($sformatf("tbl%0d.mem_resp", k), 32'(resp_a), 32'(tbl[k].e_resp));
         chk($sformatf("tbl%0d.idling", k),   32'(idl_a),  32'(tbl[k].e_idle));
         chk($sformatf("tbl%0d.w_back", k),   32'(wb_a & pw_a), 32'(tbl[k].e_wb));
         chk($sformatf("tbl%0d.alloc", k),    32'(al_a & pr_a), 32'(tbl[k].e_alloc));
         chk($sformatf("tbl%0d.victim", k),   32'(vic_a),  32'(tbl[k].e_vic));
         advance();
      end

      // 8-way clean miss, lru=5, refill answered on the third ALLOCATE cycle.
      do_reset();
      dirty_b = 8'h00; lru_b = 3'd5;
      drive(0, 1, 0, 0, 0);
      settle();
      advance();
      lru_b = 3'd1;
      for (int c = 0; c < 3; c++) begin
         pmem_resp = (c == 2);
         settle();
         chk($sformatf("w8.alloc%0d", c), 32'(al_b & pr_b), 32'd1);
         chk($sformatf("w8.victim%0d", c), 32'(vic_b), 32'd5);
         advance();
      end
      drive(0, 1, 0, 1, 0);
      settle();
      chk("w8.resp", 32'(resp_b & idl_b), 32'd1);
`ifdef CACHE_PERF_CNT_EN
      chk("w8.miss_count", 32'(mc_b), 32'd1);
`endif
      advance();

      // 4-way dirty miss, lru moves to 0 during write-back.
      do_reset();
      dirty_a = 4'b0100; lru_a = 2'd2;
      drive(0, 1, 0, 0, 0);
      settle();
      advance();
      lru_a = 2'd0; pmem_resp = 1'b0;
      settle();
      chk("dm.w_back", 32'(wb_a & pw_a), 32'd1);
      advance();
      pmem_resp = 1'b1;
      settle();
      chk("dm.victim", 32'(vic_a), 32'd2);
      advance();
      settle();
      chk("dm.alloc", 32'(al_a & pr_a), 32'd1);
      chk("dm.no_wr", 32'(pw_a), 32'd0);
`ifdef CACHE_PERF_CNT_EN
      chk("dm.wb_count", 32'(wc_a), 32'd1);
`endif
      advance();

      // Reset during ALLOCATE abandons the refill; later pmem_resp ignored.
      do_reset();
      dirty_a = 4'b0000; dirty_b = 8'h00;
      drive(0, 1, 0, 0, 0);
      settle();
      advance();
      drive(1, 0, 0, 0, 0);
      settle();
      chk("ra.alloc_before", 32'(al_a), 32'd1);
      advance();
      drive(0, 0, 0, 0, 1);
      settle();
      chk("ra.idle", 32'(idl_a), 32'd1);
      chk("ra.pmem_read", 32'(pr_a), 32'd0);
      advance();
      settle();
      chk("ra.still_idle", 32'(idl_a & ~al_a), 32'd1);
      advance();

      // Saturation: five hits on a 2-bit counter.
      do_reset();
      drive(0, 1, 0, 1, 0);
      for (int c = 0; c < 5; c++) begin
         settle();
         advance();
      end
      drive(0, 0, 0, 0, 0);
      settle();
`ifdef CACHE_PERF_CNT_EN
      chk("sat.hit_count", 32'(hc_a), 32'd3);
      chk("sat.hit_count_b", 32'(hc_b), 32'd5);
`endif
      advance();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         bit r = ($urandom_range(63) == 0);
         drive(r, r ? 1'b0 : 1'($urandom), r ? 1'b0 : 1'($urandom),
               1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0));
         dirty_a = 4'($urandom); lru_a = 2'($urandom);
         dirty_b = 8'($urandom); lru_b = 3'($urandom);
         settle();
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nway_cache_control.md
# nway_cache_control

Parametrised control FSM for an N-way set-associative, write-back, write-allocate cache, the successor to the fixed 4-way L2 controller. It sits between the cache datapath (tag/valid/dirty/LRU arrays) and physical memory and sequences hit responses, dirty-victim write-back and line allocation. It adds synchronous reset, a victim way latched at miss time, and optional performance counters.

## Interface
- WAYS, 4: associativity; power of two, ≥ 2
- CNT_W, 32: width of each performance counter (used only with the counter feature)
- WAY_W, $clog2(WAYS): derived localparam, not overridable
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_read  in  1  CPU-side read request
- mem_write  in  1  CPU-side write request
- mem_resp  out  1  request completed this cycle
- hit_any  in  1  datapath: tag hit in some way for current address
- dirty_out  in  WAYS  per-way dirty bit of the indexed set
- lru_out  in  WAY_W  datapath: LRU way of the indexed set
- victim_way  out  WAY_W  latched victim way used by the datapath for write-back and refill
- idling  out  1  FSM in IDLE
- w_back  out  1  FSM in WRITE_BACK (datapath selects victim tag/data for memory)
- alloc  out  1  FSM in ALLOCATE (datapath loads line into victim_way)
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_resp  in  1  memory completed current request
- hit_count, miss_count, wb_count  out  CNT_W each  performance counters (present only with CACHE_PERF_CNT_EN)

## Operation
- States: IDLE, WRITE_BACK, ALLOCATE. Reset state IDLE.
- IDLE: idling=1. If (mem_read|mem_write) & hit_any: mem_resp=1 (combinational). If request & ~hit_any: latch victim_way<=lru_out; next WRITE_BACK if dirty_out[lru_out] else ALLOCATE.
- WRITE_BACK: w_back=1, pmem_write=1; on pmem_resp -> ALLOCATE.
- ALLOCATE: alloc=1, pmem_read=1; on pmem_resp -> IDLE.
- mem_read & mem_write both high: treated as one request (write); no error.
- victim_way holds its value outside IDLE-miss cycles; lru_out changes during a miss are ignored.
- pmem_resp in IDLE is ignored.
- Request dropped mid-miss: transaction runs to completion; no mem_resp issued unless the request is present on return to IDLE.
- Reset mid-operation: state<=IDLE, victim_way<=0; pmem_read/pmem_write low from the cycle after the reset edge; outstanding memory transaction is abandoned.
- Reset values: mem_resp 0 (no request), idling 1, w_back 0, alloc 0, pmem_read 0, pmem_write 0, victim_way 0, counters 0.

## Timing
- Hit: mem_resp same cycle as request, 0-cycle latency.
- Clean miss: IDLE (miss) -> ALLOCATE (≥1 cycle, until pmem_resp) -> IDLE, hit and mem_resp on the first IDLE cycle.
- Dirty miss: IDLE -> WRITE_BACK -> ALLOCATE -> IDLE; pmem_write drops and pmem_read rises on the same edge, no gap cycle.
- pmem_read/pmem_write held steady until and including the cycle pmem_resp is sampled; deasserted the next cycle.
- Minimum miss: 2 cycles clean, 3 cycles dirty (pmem_resp in the first cycle of each memory state).

## Configuration
- CACHE_PERF_CNT_EN defined: hit_count increments on every cycle with mem_resp=1; miss_count on every IDLE->non-IDLE transition; wb_count on every entry into WRITE_BACK. All saturate at all-ones, clear on rst. The post-refill response counts as a hit.
- Undefined: counter ports and logic absent; FSM behaviour identical.

## Structure
- Shared package cache_pkg: state enum (IDLE, WRITE_BACK, ALLOCATE), default WAYS and CNT_W constants.
- One sub-module, sat_counter (CNT_W-wide saturating increment with synchronous clear), instantiated three times under the macro.

## Test plan
- rst high 2 cycles, then idle: idling=1, pmem_read=pmem_write=0, victim_way=0, counters=0.
- WAYS=4, mem_read=1, hit_any=1 -> mem_resp=1 same cycle, no state change; hit_count=1.
- WAYS=8, miss, lru_out=5, dirty_out=8'h00, pmem_resp after 3 cycles -> ALLOCATE 3 cycles, victim_way=5, then mem_resp with hit_any=1; miss_count=1.
- WAYS=4, miss, lru_out=2, dirty_out=4'b0100, lru_out changed to 0 during WRITE_BACK -> WRITE_BACK then ALLOCATE, victim_way stays 2; wb_count=1.
- rst asserted during ALLOCATE -> next cycle IDLE, pmem_read=0; later pmem_resp ignored.
- Counter saturation with CNT_W=2: 5 hits -> hit_count=3.
